// File: rtl/mem_dump_unit_if.sv
// Bus bundle for mem_dump_unit: the data-memory read port and the dump
// word stream toward the sink.
//   mem_rd_en  : read strobe into the data memory
//   mem_addr   : read address
//   mem_rdata  : read data, valid one cycle after mem_rd_en
//   dump_valid : a dump word is presented
//   dump_ready : sink accepts the presented word
//   dump_addr  : address of the presented word
//   dump_data  : presented word
// master = dump unit side, slave = memory/sink side.
interface mem_dump_unit_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              dump_valid;
   logic              dump_ready;
   logic [ADDR_W-1:0] dump_addr;
   logic [DATA_W-1:0] dump_data;

   modport master (
      output mem_rd_en, mem_addr,
      input  mem_rdata,
      output dump_valid, dump_addr, dump_data,
      input  dump_ready
   );

   modport slave (
      input  mem_rd_en, mem_addr,
      output mem_rdata,
      input  dump_valid, dump_addr, dump_data,
      output dump_ready
   );
endinterface

// File: rtl/mem_dump_unit.sv
// Memory dump unit: on a rising edge of the CPU halt flag, reads word_count
// words from the data memory starting at base_addr and presents each as a
// valid/ready transfer with its address.
//   clk        : clock, rising edge
//   n_rst      : asynchronous active-low reset
//   halt       : CPU halt flag; 0->1 starts a dump, 1->0 aborts/clears done
//   base_addr  : first address, sampled on the start edge
//   word_count : words to dump (clamped to 2^ADDR_W), sampled on start edge
//   dump_done  : dump complete, held until halt drops
//   bus        : memory read port and dump stream (master side)
module mem_dump_unit #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              halt,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   output logic              dump_done,
   mem_dump_unit_if.master   bus
);

   typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

   localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state;
   logic              halt_q;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   remaining;
   logic              start;
   logic [ADDR_W:0]   count_clamped;

   // halt_q resets to 0, so a halt already high at reset release starts a dump
   assign start = halt & ~halt_q;

   // More than 2^ADDR_W words would revisit addresses; cap at one full sweep
   assign count_clamped = (word_count > MAX_CNT) ? MAX_CNT : word_count;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state          <= IDLE;
         halt_q         <= 1'b0;
         ptr            <= '0;
         remaining      <= '0;
         dump_done      <= 1'b0;
         bus.mem_rd_en  <= 1'b0;
         bus.mem_addr   <= '0;
         bus.dump_valid <= 1'b0;
         bus.dump_addr  <= '0;
         bus.dump_data  <= '0;
      end else begin
         halt_q <= halt;
         case (state)
            IDLE: begin
               if (start) begin
                  ptr <= base_addr;
                  if (count_clamped == '0) begin
                     dump_done <= 1'b1;
                     state     <= DONE;
                  end else begin
                     remaining     <= count_clamped;
                     bus.mem_rd_en <= 1'b1;
                     bus.mem_addr  <= base_addr;
                     state         <= READ;
                  end
               end
            end
            READ: begin
               bus.mem_rd_en <= 1'b0;
               state         <= halt ? WAIT : IDLE;
            end
            WAIT: begin
               if (!halt) begin
                  state <= IDLE;
               end else begin
                  bus.dump_data  <= bus.mem_rdata;
                  bus.dump_addr  <= ptr;
                  bus.dump_valid <= 1'b1;
                  state          <= SEND;
               end
            end
            SEND: begin
               if (!halt) begin
                  // abort: the dump is discarded, pointer state is reloaded on restart
                  bus.dump_valid <= 1'b0;
                  state          <= IDLE;
               end else if (bus.dump_ready) begin
                  bus.dump_valid <= 1'b0;
                  ptr            <= ptr + 1'b1;
                  remaining      <= remaining - ONE;
                  if (remaining == ONE) begin
                     dump_done <= 1'b1;
                     state     <= DONE;
                  end else begin
                     bus.mem_rd_en <= 1'b1;
                     bus.mem_addr  <= ptr + 1'b1;
                     state         <= READ;
                  end
               end
            end
            DONE: begin
               if (!halt) begin
                  dump_done <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_dump_unit.md
MEM_DUMP_UNIT -- requirements
Module: mem_dump_unit

Interface
REQ-001: Parameter DATA_W, default 16, data-memory word width.
REQ-002: Parameter ADDR_W, default 8, data-memory address width.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: n_rst  input  1  asynchronous active-low reset.
REQ-005: halt  input  1  CPU halt flag; rising edge (0 then 1 on consecutive edges) starts a dump.
REQ-006: base_addr  input  ADDR_W  first word to dump; sampled on the start edge.
REQ-007: word_count  input  ADDR_W+1  number of words to dump; sampled on the start edge.
REQ-008: mem_rd_en  output  1  data-memory read strobe.
REQ-009: mem_addr  output  ADDR_W  data-memory read address.
REQ-010: mem_rdata  input  DATA_W  read data; valid exactly one cycle after mem_rd_en.
REQ-011: dump_valid  output  1  dump word available.
REQ-012: dump_ready  input  1  sink accepts the word.
REQ-013: dump_addr  output  ADDR_W  address of the presented word.
REQ-014: dump_data  output  DATA_W  presented word.
REQ-015: dump_done  output  1  dump complete; held until halt deasserts.

Function
REQ-016: FSM states SHALL be IDLE, READ, WAIT, SEND and DONE.
REQ-017: IDLE: start edge with word_count>0 -> READ; start edge with word_count=0 -> DONE; otherwise stay.
REQ-018: READ: assert mem_rd_en for one cycle with mem_addr=current pointer -> WAIT.
REQ-019: WAIT: capture mem_rdata into dump_data, current pointer into dump_addr -> SEND.
REQ-020: SEND: dump_valid=1; dump_data and dump_addr stable while dump_valid=1 and dump_ready=0.
REQ-021: Transfer occurs on an edge with dump_valid=1 and dump_ready=1; pointer increments, remaining count decrements.
REQ-022: After transfer: remaining count 0 -> DONE; otherwise -> READ.
REQ-023: Minimum per-word cost SHALL be 3 cycles (READ, WAIT, SEND with ready held high).
REQ-024: Pointer arithmetic SHALL be modulo 2^ADDR_W: address 2^ADDR_W-1 is followed by 0.
REQ-025: word_count above 2^ADDR_W SHALL be clamped to 2^ADDR_W; each address is emitted at most once per dump.
REQ-026: DONE: dump_done=1, dump_valid=0; halt=0 -> IDLE.
REQ-027: halt falling while in READ, WAIT or SEND SHALL abort: next state IDLE, dump_valid=0 next cycle, no transfer counted on that edge unless dump_ready was also 1.
REQ-028: Halt held high after DONE or after an abort SHALL NOT restart a dump; a new rising edge is required.
REQ-029: mem_rd_en SHALL be 0 in every state except READ.
REQ-030: base_addr and word_count changes after the start edge SHALL have no effect on the dump in progress.

Reset
REQ-031: n_rst=0 SHALL immediately force IDLE, mem_rd_en=0, mem_addr=0, dump_valid=0, dump_addr=0, dump_data=0 and dump_done=0, independent of clk.
REQ-032: Reset mid-dump SHALL discard the dump; after release no dump starts until a new halt rising edge.
REQ-033: The halt edge detector SHALL reset to 0, so halt already high at reset release counts as a rising edge on the first clock.

Verification
REQ-034: Memory words 1..5 = 1..5, base_addr=1, word_count=5, halt rises, dump_ready=1 -> five transfers (addr,data) = (1,1)..(5,5) on edges 3,6,9,12,15 after start; dump_done=1 afterward.
REQ-035: word_count=0, halt rises -> dump_done=1 one cycle later; mem_rd_en and dump_valid stay 0.
REQ-036: base_addr=2^ADDR_W-2, word_count=4 -> addresses 254,255,0,1 for ADDR_W=8.
REQ-037: dump_ready held 0 for 7 cycles while dump_valid=1 -> dump_data and dump_addr unchanged, no extra mem_rd_en; transfer on first edge with ready=1.
REQ-038: halt drops during the third word's SEND with dump_ready=0 -> dump_valid=0 next cycle, FSM in IDLE, dump_done stays 0; a new halt edge restarts from base_addr.
REQ-039: n_rst pulsed low during WAIT -> all outputs 0 asynchronously; halt held high through release -> a fresh dump from base_addr starts on the first clock.
